core_io_bridge: RTL and testbench

Parametrised board-I/O front end between the physical switches/buttons and an N-core CPU array, replacing the fixed two-core, 8-bit select-and-display wiring. Raw inputs are synchronised and debounced. The selected core's input register is loaded from the data switches, each core's output port is captured, and the `{in, out}` pair of the selected core drives the display digit bus. Sits in the top module between board pins and the core array / seven-segment driver.

---
 rtl/core_io_bridge.sv | 151 +++++++++++++++
 tb/tb_core_io_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_io_bridge.sv
// core_io_bridge: board-I/O front end for an N-core CPU array.
// Raw switches/buttons are synchronised and debounced. The active core's input
// register is loaded from the data switches, every core's output port is
// captured, and the active core's {in, out} pair drives the digit bus.
module core_io_bridge #(
    parameter int unsigned N_CORES         = 4,
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned SEL_W           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          AUTO_LOAD       = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           sw_data,
    input  logic [SEL_W-1:0]            sw_sel,
    input  logic [3:0]                  buttons,
    output logic [N_CORES*DATA_W-1:0]   core_in,
    output logic [N_CORES-1:0]          core_in_valid,
    input  logic [N_CORES*DATA_W-1:0]   core_out,
    input  logic [N_CORES-1:0]          core_out_valid,
    output logic [SEL_W-1:0]            active_core,
    output logic [2*DATA_W-1:0]         digits,
    output logic [3:0]                  btn_pulse
);

    // All raw inputs are debounced as one vector: {buttons, sw_sel, sw_data}.
    localparam int unsigned RAW_W   = DATA_W + SEL_W + 4;
    localparam int unsigned SEL_LSB = DATA_W;
    localparam int unsigned BTN_LSB = DATA_W + SEL_W;
    // The counter only has to reach DEBOUNCE_CYCLES-1 before the value flips.
    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [RAW_W-1:0]              raw;
    logic [RAW_W-1:0]              sync1_q, sync2_q;
    logic [RAW_W-1:0]              deb_q, deb_d;
    logic [RAW_W-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]             deb_data;
    logic [SEL_W-1:0]              deb_sel;
    logic [DATA_W-1:0]             data_prev_q;
    logic                          data_change;
    logic                          sel_in_range;
    logic                          load_en;
    logic                          clear_en;

    logic [3:0]                    btn_pulse_q, btn_pulse_d;
    logic [SEL_W-1:0]              active_q, active_d;
    logic [N_CORES-1:0][DATA_W-1:0] in_q, in_d;
    logic [N_CORES-1:0][DATA_W-1:0] out_q, out_d;
    logic [N_CORES-1:0]            valid_q, valid_d;
    logic [2*DATA_W-1:0]           digits_q, digits_d;

    assign raw = {buttons, sw_sel, sw_data};

    // Two-flop synchroniser for every raw bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking here so both flops sample pre-edge values and form a real two-stage chain.
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: flip after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < RAW_W; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign deb_data     = deb_q[DATA_W-1:0];
    assign deb_sel      = deb_q[SEL_LSB +: SEL_W];
    assign data_change  = (deb_data != data_prev_q);
    assign sel_in_range = (32'(deb_sel) < N_CORES);
    assign btn_pulse_d  = deb_d[BTN_LSB +: 4] & ~deb_q[BTN_LSB +: 4];
    assign load_en      = AUTO_LOAD ? data_change : btn_pulse_q[0];
    assign clear_en     = btn_pulse_q[1];

    // Core selection, load/clear/capture of the register banks, digit mux.
    always_comb begin
        // A valid select applies before the load, so data lands on the new core.
        active_d = sel_in_range ? deb_sel : active_q;
        in_d     = in_q;
        out_d    = out_q;
        valid_d  = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (clear_en && active_d == SEL_W'(k)) begin
                in_d[k]  = '0;
                out_d[k] = '0;
            end
            // Load overrides clear on in_reg; capture overrides clear on out_reg.
            if (load_en && active_d == SEL_W'(k)) begin
                in_d[k]    = deb_data;
                valid_d[k] = 1'b1;
            end
            if (core_out_valid[k]) begin
                out_d[k] = core_out[k*DATA_W +: DATA_W];
            end
        end
        digits_d = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (active_q == SEL_W'(k)) begin
                digits_d = {in_q[k], out_q[k]};
            end
        end
    end

    // State registers; reset also drops any pending load or button edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q       <= '0;
            cnt_q       <= '0;
            data_prev_q <= '0;
            btn_pulse_q <= '0;
            active_q    <= '0;
            in_q        <= '0;
            out_q       <= '0;
            valid_q     <= '0;
            digits_q    <= '0;
        end else begin
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            data_prev_q <= deb_data;
            btn_pulse_q <= btn_pulse_d;
            active_q    <= active_d;
            in_q        <= in_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            digits_q    <= digits_d;
        end
    end

    assign core_in       = in_q;
    assign core_in_valid = valid_q;
    assign active_core   = active_q;
    assign digits        = digits_q;
    assign btn_pulse     = btn_pulse_q;

endmodule

// File: tb/tb_core_io_bridge.sv
// Directed bench for core_io_bridge. Instance A: 4 cores, auto-load,
// 16-cycle debounce. Instance B: 3 cores, button load, 4-cycle debounce.
module tb_core_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sw_data;
    logic [3:0]  sw_sel;
    logic [3:0]  buttons;
    logic [31:0] core_out;
    logic [3:0]  core_out_valid;

    logic [31:0] a_core_in;
    logic [3:0]  a_valid;
    logic [3:0]  a_active;
    logic [15:0] a_digits;
    logic [3:0]  a_btn;

    logic [23:0] b_core_in;
    logic [2:0]  b_valid;
    logic [3:0]  b_active;
    logic [15:0] b_digits;
    logic [3:0]  b_btn;

    int checks = 0;
    int errors = 0;
    int a_strobes [4] = '{default: 0};
    int b_strobes [3] = '{default: 0};

    always #5 clk = ~clk;

    core_io_bridge #(
        .N_CORES(4), .DATA_W(8), .SEL_W(4), .DEBOUNCE_CYCLES(16), .AUTO_LOAD(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .sw_data(sw_data), .sw_sel(sw_sel), .buttons(buttons),
        .core_in(a_core_in), .core_in_valid(a_valid), .core_out(core_out),
        .core_out_valid(core_out_valid), .active_core(a_active), .digits(a_digits),
        .btn_pulse(a_btn)
    );

    core_io_bridge #(
        .N_CORES(3), .DATA_W(8), .SEL_W(4), .DEBOUNCE_CYCLES(4), .AUTO_LOAD(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .sw_data(sw_data), .sw_sel(sw_sel), .buttons(buttons),
        .core_in(b_core_in), .core_in_valid(b_valid), .core_out(core_out[23:0]),
        .core_out_valid(core_out_valid[2:0]), .active_core(b_active), .digits(b_digits),
        .btn_pulse(b_btn)
    );

    // Count input-load strobes per core, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (a_valid[k]) a_strobes[k]++;
        for (int k = 0; k < 3; k++) if (b_valid[k]) b_strobes[k]++;
    end

    function automatic int a_total();
        return a_strobes[0] + a_strobes[1] + a_strobes[2] + a_strobes[3];
    endfunction

    function automatic int b_total();
        return b_strobes[0] + b_strobes[1] + b_strobes[2];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit off the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int a_base;
    int b_base;

    initial begin
        reset = 1'b0; sw_data = '0; sw_sel = '0; buttons = '0;
        core_out = '0; core_out_valid = '0;

        // Reset state
        tick(5);
        check("rst_a_active", 32'(a_active), 32'd0);
        check("rst_a_core_in", a_core_in, 32'h0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_digits", 32'(a_digits), 32'h0);
        check("rst_a_btn", 32'(a_btn), 32'd0);
        check("rst_b_core_in", 32'(b_core_in), 32'h0);
        reset = 1'b1;

        // Auto-load into core 2; debounced change at edge 18, load at edge 19
        sw_sel = 4'd2; sw_data = 8'h5A;
        tick(18);
        check("t1_no_early_strobe", 32'(a_valid), 32'd0);
        tick(1);
        check("t1_strobe", 32'(a_valid), 32'b0100);
        check("t1_core_in", a_core_in, 32'h005A_0000);
        check("t1_active", 32'(a_active), 32'd2);
        tick(1);
        check("t1_strobe_drop", 32'(a_valid), 32'd0);
        check("t1_digits", 32'(a_digits), 32'h5A00);
        tick(20);
        check("t1_one_strobe_core2", 32'(a_strobes[2]), 32'd1);
        check("t1_one_strobe_total", 32'(a_total()), 32'd1);

        // Glitch of 10 cycles is shorter than the 16-cycle window
        sw_data = 8'hFF;
        tick(10);
        sw_data = 8'h5A;
        tick(30);
        check("t2_no_strobe", 32'(a_total()), 32'd1);
        check("t2_core_in_kept", a_core_in, 32'h005A_0000);

        // Select and data change together: data lands on newly selected core 0
        sw_sel = 4'd0; sw_data = 8'h77;
        tick(22);
        check("t5_active0", 32'(a_active), 32'd0);
        check("t5_core_in", a_core_in, 32'h005A_0077);
        check("t5_digits_in", 32'(a_digits), 32'h7700);
        check("t5_strobe_core0", 32'(a_strobes[0]), 32'd1);

        // Capture on core 0; digits follow one cycle after out_reg updates
        core_out = 32'h0000_0033; core_out_valid = 4'b0001;
        tick(1);
        check("t5_digits_lag", 32'(a_digits), 32'h7700);
        core_out_valid = 4'b0000;
        tick(1);
        check("t5_digits_capture", 32'(a_digits), 32'h7733);

        // Clear button: pulse at edge 18, clear at 19, digits at 20
        buttons = 4'b0010;
        tick(18);
        check("t5_clear_pulse", 32'(a_btn), 32'b0010);
        tick(1);
        check("t5_clear_pulse_drop", 32'(a_btn), 32'd0);
        check("t5_clear_no_strobe", 32'(a_valid), 32'd0);
        tick(1);
        check("t5_clear_digits", 32'(a_digits), 32'h0000);
        check("t5_clear_core_in", a_core_in, 32'h005A_0000);
        buttons = 4'b0000;
        tick(20);
        check("t5_release_no_pulse", 32'(a_btn), 32'd0);

        // Clear and capture on the same edge: in_reg cleared, out_reg captured
        sw_data = 8'h66;
        tick(22);
        check("t5_reload_digits", 32'(a_digits), 32'h6600);
        check("t5_reload_strobes", 32'(a_strobes[0]), 32'd2);
        buttons = 4'b0010;
        tick(18);
        core_out = 32'h0000_0044; core_out_valid = 4'b0001;
        tick(1);
        core_out_valid = 4'b0000;
        tick(1);
        check("t5_clear_vs_capture", 32'(a_digits), 32'h0044);
        buttons = 4'b0000;
        tick(20);

        // Reset with a load pending (debounced change at edge 18, load due at 19)
        sw_data = 8'h99;
        tick(18);
        reset = 1'b0;
        #1;
        check("t6_async_core_in", a_core_in, 32'h0);
        check("t6_async_digits", 32'(a_digits), 32'h0);
        check("t6_async_active", 32'(a_active), 32'd0);
        sw_data = '0; sw_sel = '0; buttons = '0; core_out = '0;
        tick(3);
        reset = 1'b1;
        a_base = a_total();
        b_base = b_total();
        tick(30);
        check("t6_no_spurious_strobe", 32'(a_total() - a_base), 32'd0);
        check("t6_core_in_zero", a_core_in, 32'h0);

        // Select core 1, then out-of-range 5 is ignored by both instances
        sw_sel = 4'd1;
        tick(20);
        check("t3_b_active1", 32'(b_active), 32'd1);
        sw_sel = 4'd5;
        tick(40);
        check("t3_b_active_kept", 32'(b_active), 32'd1);
        check("t3_a_active_kept", 32'(a_active), 32'd1);

        // Button-load mode: data changes alone load nothing
        sw_data = 8'h11;
        tick(20);
        sw_data = 8'h22;
        tick(20);
        check("t4_no_load", 32'(b_core_in), 32'h0);
        check("t4_no_strobe", 32'(b_total() - b_base), 32'd0);
        check("t3_a_autoload_core1", a_core_in, 32'h0000_2200);

        // Clean buttons[0] press: pulse at edge 6, load at 7, digits at 8
        buttons = 4'b0001;
        tick(6);
        check("t4_load_pulse", 32'(b_btn), 32'b0001);
        tick(1);
        check("t4_strobe", 32'(b_valid), 32'b010);
        check("t4_core_in", 32'(b_core_in), 32'h00_2200);
        tick(1);
        check("t4_strobe_drop", 32'(b_valid), 32'd0);
        check("t4_digits", 32'(b_digits), 32'h2200);
        buttons = 4'b0000;
        tick(10);
        check("t4_one_strobe", 32'(b_total() - b_base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
